// File: rtl/id_inst_buffer_if.sv
// Handshake bundle between the instruction cache, the ID instruction buffer and decode.
// The master modport is the environment side and drives pushes, flush and decode-ready.
interface id_inst_buffer_if #(
    parameter int DEPTH  = 4,
    parameter int PC_W   = 32,
    parameter int INST_W = 32
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic              flush;
    logic              in_valid;
    logic              in_ready;
    logic [PC_W-1:0]   in_pc;
    logic [INST_W-1:0] in_inst;
    logic              out_valid;
    logic              out_ready;
    logic [PC_W-1:0]   out_pc;
    logic [INST_W-1:0] out_inst;
    logic [CW-1:0]     count;
    logic              almost_full;

    modport master (
        output flush, in_valid, in_pc, in_inst, out_ready,
        input  in_ready, out_valid, out_pc, out_inst, count, almost_full
    );

    modport slave (
        input  flush, in_valid, in_pc, in_inst, out_ready,
        output in_ready, out_valid, out_pc, out_inst, count, almost_full
    );
endinterface

// File: rtl/id_inst_buffer.sv
// Instruction buffer between IC and decode: circular pc/inst array plus a registered
// output stage. Empty-array pushes bypass straight into the output stage.
module id_inst_buffer #(
    parameter int DEPTH    = 4,
    parameter int PC_W     = 32,
    parameter int INST_W   = 32,
    parameter int AF_LEVEL = DEPTH - 1
) (
    input  logic            clk,
    input  logic            rst,
    id_inst_buffer_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [PC_W-1:0]   r_mem_pc   [DEPTH];
    logic [INST_W-1:0] r_mem_inst [DEPTH];

    logic [AW-1:0]     r_wr_ptr;
    logic [AW-1:0]     r_rd_ptr;
    logic [CW-1:0]     r_count;
    logic              r_out_valid;
    logic [PC_W-1:0]   r_out_pc;
    logic [INST_W-1:0] r_out_inst;

    logic [AW-1:0]     w_wr_ptr_nxt;
    logic [AW-1:0]     w_rd_ptr_nxt;
    logic [CW-1:0]     w_count_nxt;
    logic              w_out_valid_nxt;
    logic [PC_W-1:0]   w_out_pc_nxt;
    logic [INST_W-1:0] w_out_inst_nxt;

    logic w_in_ready;
    logic w_push;
    logic w_load;
    logic w_pop;
    logic w_bypass;
    logic w_wr_en;

    // A same-cycle pop never relieves in_ready: it looks only at the registered count.
    assign w_in_ready = (r_count < CW'(DEPTH));
    assign w_push     = bus.in_valid && w_in_ready;
    assign w_load     = !r_out_valid || bus.out_ready;
    assign w_pop      = w_load && (r_count != {CW{1'b0}});
    assign w_bypass   = w_load && (r_count == {CW{1'b0}}) && w_push;
    assign w_wr_en    = w_push && !w_bypass;

    // Next-state for pointers, occupancy and the output stage.
    always_comb begin
        w_wr_ptr_nxt    = r_wr_ptr;
        w_rd_ptr_nxt    = r_rd_ptr;
        w_count_nxt     = r_count + CW'(w_wr_en) - CW'(w_pop);
        w_out_valid_nxt = r_out_valid;
        w_out_pc_nxt    = r_out_pc;
        w_out_inst_nxt  = r_out_inst;

        if (w_wr_en) begin
            w_wr_ptr_nxt = r_wr_ptr + AW'(1);
        end else begin
            w_wr_ptr_nxt = r_wr_ptr;
        end

        if (w_pop) begin
            w_rd_ptr_nxt = r_rd_ptr + AW'(1);
        end else begin
            w_rd_ptr_nxt = r_rd_ptr;
        end

        // Head of the array has priority over the bypass so order is preserved.
        if (w_load) begin
            if (w_pop) begin
                w_out_valid_nxt = 1'b1;
                w_out_pc_nxt    = r_mem_pc[r_rd_ptr];
                w_out_inst_nxt  = r_mem_inst[r_rd_ptr];
            end else if (w_bypass) begin
                w_out_valid_nxt = 1'b1;
                w_out_pc_nxt    = bus.in_pc;
                w_out_inst_nxt  = bus.in_inst;
            end else begin
                w_out_valid_nxt = 1'b0;
                w_out_pc_nxt    = {PC_W{1'b0}};
                w_out_inst_nxt  = {INST_W{1'b0}};
            end
        end else begin
            w_out_valid_nxt = r_out_valid;
            w_out_pc_nxt    = r_out_pc;
            w_out_inst_nxt  = r_out_inst;
        end
    end

    // Control and output-stage registers; reset dominates flush, flush dominates traffic.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr    <= {AW{1'b0}};
            r_rd_ptr    <= {AW{1'b0}};
            r_count     <= {CW{1'b0}};
            r_out_valid <= 1'b0;
            r_out_pc    <= {PC_W{1'b0}};
            r_out_inst  <= {INST_W{1'b0}};
        end else if (bus.flush) begin
            r_wr_ptr    <= {AW{1'b0}};
            r_rd_ptr    <= {AW{1'b0}};
            r_count     <= {CW{1'b0}};
            r_out_valid <= 1'b0;
            r_out_pc    <= {PC_W{1'b0}};
            r_out_inst  <= {INST_W{1'b0}};
        end else begin
            r_wr_ptr    <= w_wr_ptr_nxt;
            r_rd_ptr    <= w_rd_ptr_nxt;
            r_count     <= w_count_nxt;
            r_out_valid <= w_out_valid_nxt;
            r_out_pc    <= w_out_pc_nxt;
            r_out_inst  <= w_out_inst_nxt;
        end
    end

    // Storage array write port; contents need no reset since count gates every read.
    always_ff @(posedge clk) begin
        if (w_wr_en && !bus.flush && !rst) begin
            r_mem_pc[r_wr_ptr]   <= bus.in_pc;
            r_mem_inst[r_wr_ptr] <= bus.in_inst;
        end
    end

    assign bus.in_ready    = w_in_ready;
    assign bus.out_valid   = r_out_valid;
    assign bus.out_pc      = r_out_pc;
    assign bus.out_inst    = r_out_inst;
    assign bus.count       = r_count;
    assign bus.almost_full = (r_count >= CW'(AF_LEVEL));
endmodule

// File: tb/tb_id_inst_buffer.sv
// Randomised and directed bench for id_inst_buffer against a queue-level reference model.
module tb_id_inst_buffer;
    localparam int DEPTH    = 4;
    localparam int PC_W     = 32;
    localparam int INST_W   = 32;
    localparam int AF_LEVEL = DEPTH - 1;
    localparam int CW       = $clog2(DEPTH) + 1;
    localparam int VW       = 1 + PC_W + INST_W + CW + 2;

    logic clk;
    logic rst;

    id_inst_buffer_if #(.DEPTH(DEPTH), .PC_W(PC_W), .INST_W(INST_W)) bus ();

    id_inst_buffer #(.DEPTH(DEPTH), .PC_W(PC_W), .INST_W(INST_W), .AF_LEVEL(AF_LEVEL)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    // Model: every instruction held by the block, output stage first.
    logic [PC_W-1:0]   m_pc   [$];
    logic [INST_W-1:0] m_inst [$];
    logic [PC_W-1:0]   obs_pc [$];
    bit                last_push;

    function automatic bit m_valid();
        return m_pc.size() > 0;
    endfunction

    function automatic int m_count();
        return (m_pc.size() > 0) ? m_pc.size() - 1 : 0;
    endfunction

    function automatic logic [VW-1:0] m_vec();
        logic [PC_W-1:0]   pc;
        logic [INST_W-1:0] inst;
        pc   = m_valid() ? m_pc[0] : '0;
        inst = m_valid() ? m_inst[0] : '0;
        return {m_valid(), pc, inst, CW'(m_count()), (m_count() < DEPTH), (m_count() >= AF_LEVEL)};
    endfunction

    function automatic logic [VW-1:0] dut_vec();
        return {bus.out_valid, bus.out_pc, bus.out_inst, bus.count, bus.in_ready, bus.almost_full};
    endfunction

    task automatic tick();
        bit r, f, pop, push;
        logic [PC_W-1:0]   pc;
        logic [INST_W-1:0] inst;
        r    = rst;
        f    = bus.flush;
        pop  = m_valid() && bus.out_ready;
        push = bus.in_valid && (m_count() < DEPTH);
        pc   = bus.in_pc;
        inst = bus.in_inst;
        if (!r && !f && bus.out_valid && bus.out_ready) obs_pc.push_back(bus.out_pc);
        @(posedge clk);
        last_push = push && !r && !f;
        if (r || f) begin
            m_pc.delete();
            m_inst.delete();
        end else begin
            if (pop) begin
                void'(m_pc.pop_front());
                void'(m_inst.pop_front());
            end
            if (push) begin
                m_pc.push_back(pc);
                m_inst.push_back(inst);
            end
        end
        #1;
    endtask

    task automatic clean();
        bus.flush = 1'b1; bus.in_valid = 1'b0; bus.out_ready = 1'b0;
        tick();
        bus.flush = 1'b0;
        obs_pc.delete();
    endtask

    task automatic push_one(input logic [PC_W-1:0] pc);
        bus.in_valid = 1'b1; bus.in_pc = pc; bus.in_inst = $urandom;
        tick();
        bus.in_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; bus.flush = 1'b0; bus.in_valid = 1'b0; bus.out_ready = 1'b0;
        bus.in_pc = '0; bus.in_inst = '0;
        tick(); tick();
        rst = 1'b0;
        n_cmp++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", bus.out_valid); end
        n_cmp++; if (bus.out_pc !== 32'h0) begin n_fail++; $display("FAIL reset_out_pc: got %h want 0", bus.out_pc); end
        n_cmp++; if (bus.out_inst !== 32'h0) begin n_fail++; $display("FAIL reset_out_inst: got %h want 0", bus.out_inst); end
        n_cmp++; if (bus.count !== 3'd0) begin n_fail++; $display("FAIL reset_count: got %0d want 0", bus.count); end
        n_cmp++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b want 1", bus.in_ready); end
        n_cmp++; if (bus.almost_full !== 1'b0) begin n_fail++; $display("FAIL reset_almost_full: got %b want 0", bus.almost_full); end
    endtask

    task automatic test_bypass();
        clean();
        bus.out_ready = 1'b1; bus.in_valid = 1'b1;
        bus.in_pc = 32'hBFC0_0000; bus.in_inst = 32'h2408_0001;
        tick();
        bus.in_valid = 1'b0;
        n_cmp++; if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL bypass_valid: got %b want 1", bus.out_valid); end
        n_cmp++; if (bus.out_pc !== 32'hBFC0_0000) begin n_fail++; $display("FAIL bypass_pc: got %h want bfc00000", bus.out_pc); end
        n_cmp++; if (bus.out_inst !== 32'h2408_0001) begin n_fail++; $display("FAIL bypass_inst: got %h want 24080001", bus.out_inst); end
        n_cmp++; if (bus.count !== 3'd0) begin n_fail++; $display("FAIL bypass_count: got %0d want 0", bus.count); end
        tick();
        n_cmp++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL bypass_drain: got %b want 0", bus.out_valid); end
    endtask

    task automatic test_stall_fill();
        clean();
        for (int i = 0; i < 5; i++) begin
            push_one(32'h1000 + 32'(4 * i));
            n_cmp++; if (bus.count !== CW'(i)) begin n_fail++; $display("FAIL fill_count%0d: got %0d want %0d", i, bus.count, i); end
            n_cmp++; if (bus.almost_full !== (i >= 3)) begin n_fail++; $display("FAIL fill_af%0d: got %b want %b", i, bus.almost_full, i >= 3); end
            n_cmp++; if (bus.in_ready !== (i < 4)) begin n_fail++; $display("FAIL fill_ready%0d: got %b want %b", i, bus.in_ready, i < 4); end
        end
        push_one(32'hDEAD_0000);
        n_cmp++; if (bus.count !== 3'd4) begin n_fail++; $display("FAIL fill_reject_count: got %0d want 4", bus.count); end
        n_cmp++; if (bus.out_pc !== 32'h1000) begin n_fail++; $display("FAIL stall_hold: got %h want 1000", bus.out_pc); end
        bus.out_ready = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            tick();
            n_cmp++; if (bus.out_pc !== 32'h1000 + 32'(4 * k) || bus.out_valid !== 1'b1) begin
                n_fail++; $display("FAIL release%0d: got %b/%h want 1/%h", k, bus.out_valid, bus.out_pc, 32'h1000 + 32'(4 * k));
            end
            n_cmp++; if (bus.count !== CW'(4 - k)) begin n_fail++; $display("FAIL release_count%0d: got %0d want %0d", k, bus.count, 4 - k); end
        end
        tick();
        n_cmp++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL release_empty: got %b want 0", bus.out_valid); end
    endtask

    task automatic test_wrap();
        int sent = 0;
        int cyc = 0;
        clean();
        while (sent < 3 * DEPTH && cyc < 200) begin
            bus.in_valid = 1'b1; bus.in_pc = 32'h2000 + 32'(4 * sent); bus.in_inst = $urandom;
            bus.out_ready = (cyc % 2 == 0);
            tick();
            if (last_push) sent++;
            cyc++;
            n_cmp++; if (dut_vec() !== m_vec()) begin n_fail++; $display("FAIL wrap_cycle%0d: got %h want %h", cyc, dut_vec(), m_vec()); end
        end
        bus.in_valid = 1'b0;
        while (m_valid() && cyc < 400) begin
            bus.out_ready = (cyc % 2 == 0);
            tick();
            cyc++;
            n_cmp++; if (dut_vec() !== m_vec()) begin n_fail++; $display("FAIL wrap_drain%0d: got %h want %h", cyc, dut_vec(), m_vec()); end
        end
        n_cmp++; if (sent != 3 * DEPTH || m_valid()) begin n_fail++; $display("FAIL wrap_timeout: got sent %0d want %0d", sent, 3 * DEPTH); end
        n_cmp++; if (obs_pc.size() != 3 * DEPTH) begin n_fail++; $display("FAIL wrap_delivered: got %0d want %0d", obs_pc.size(), 3 * DEPTH); end
        for (int i = 0; i < obs_pc.size() && i < 3 * DEPTH; i++) begin
            n_cmp++; if (obs_pc[i] !== 32'h2000 + 32'(4 * i)) begin n_fail++; $display("FAIL wrap_order%0d: got %h want %h", i, obs_pc[i], 32'h2000 + 32'(4 * i)); end
        end
    endtask

    task automatic test_flush();
        clean();
        for (int i = 0; i < 4; i++) push_one(32'h3000 + 32'(4 * i));
        n_cmp++; if (bus.count !== 3'd3 || bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL flush_setup: got %0d/%b want 3/1", bus.count, bus.out_valid); end
        bus.flush = 1'b1; bus.in_valid = 1'b1; bus.in_pc = 32'h3100; bus.out_ready = 1'b1;
        tick();
        bus.flush = 1'b0; bus.in_valid = 1'b0;
        n_cmp++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_valid: got %b want 0", bus.out_valid); end
        n_cmp++; if (bus.out_pc !== 32'h0 || bus.out_inst !== 32'h0) begin n_fail++; $display("FAIL flush_nop: got %h/%h want 0/0", bus.out_pc, bus.out_inst); end
        n_cmp++; if (bus.count !== 3'd0 || bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL flush_count: got %0d/%b want 0/1", bus.count, bus.in_ready); end
        push_one(32'h3200);
        n_cmp++; if (bus.out_valid !== 1'b1 || bus.out_pc !== 32'h3200) begin n_fail++; $display("FAIL flush_next: got %b/%h want 1/3200", bus.out_valid, bus.out_pc); end
    endtask

    task automatic test_full_simultaneous();
        int cyc = 0;
        clean();
        for (int i = 0; i < 5; i++) push_one(32'h4000 + 32'(4 * i));
        n_cmp++; if (bus.count !== 3'd4) begin n_fail++; $display("FAIL full_count: got %0d want 4", bus.count); end
        bus.out_ready = 1'b1; bus.in_valid = 1'b1; bus.in_pc = 32'h4FFC;
        n_cmp++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL full_in_ready: got %b want 0", bus.in_ready); end
        tick();
        bus.in_valid = 1'b0;
        n_cmp++; if (bus.count !== 3'd3 || bus.out_pc !== 32'h4004) begin n_fail++; $display("FAIL full_pop: got %0d/%h want 3/4004", bus.count, bus.out_pc); end
        while (m_valid() && cyc < 20) begin tick(); cyc++; end
        n_cmp++; if (obs_pc.size() != 5) begin n_fail++; $display("FAIL full_delivered: got %0d want 5", obs_pc.size()); end
        for (int i = 0; i < obs_pc.size() && i < 5; i++) begin
            n_cmp++; if (obs_pc[i] !== 32'h4000 + 32'(4 * i)) begin n_fail++; $display("FAIL full_order%0d: got %h want %h", i, obs_pc[i], 32'h4000 + 32'(4 * i)); end
        end
    endtask

    task automatic test_reset_midstream();
        clean();
        for (int i = 0; i < 3; i++) push_one(32'h5000 + 32'(4 * i));
        n_cmp++; if (bus.count !== 3'd2) begin n_fail++; $display("FAIL rstmid_setup: got %0d want 2", bus.count); end
        rst = 1'b1; bus.flush = 1'b1; bus.in_valid = 1'b1; bus.in_pc = 32'h5555;
        tick();
        rst = 1'b0; bus.flush = 1'b0; bus.in_valid = 1'b0;
        n_cmp++; if (bus.out_valid !== 1'b0 || bus.out_pc !== 32'h0 || bus.out_inst !== 32'h0 || bus.count !== 3'd0) begin
            n_fail++; $display("FAIL rstmid_clear: got %b/%h/%h/%0d want 0/0/0/0", bus.out_valid, bus.out_pc, bus.out_inst, bus.count);
        end
        push_one(32'h5100);
        n_cmp++; if (bus.out_valid !== 1'b1 || bus.out_pc !== 32'h5100) begin n_fail++; $display("FAIL rstmid_push: got %b/%h want 1/5100", bus.out_valid, bus.out_pc); end
    endtask

    task automatic test_random();
        clean();
        for (int c = 0; c < 400; c++) begin
            bus.in_valid  = ($urandom_range(0, 3) != 0);
            bus.out_ready = ($urandom_range(0, 2) != 0) ^ (c >= 200 && c < 260);
            bus.flush     = ($urandom_range(0, 31) == 0);
            bus.in_pc     = $urandom;
            bus.in_inst   = $urandom;
            tick();
            n_cmp++; if (dut_vec() !== m_vec()) begin n_fail++; $display("FAIL random_cycle%0d: got %h want %h", c, dut_vec(), m_vec()); end
        end
        bus.flush = 1'b0; bus.in_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_bypass();
        test_stall_fill();
        test_wrap();
        test_flush();
        test_full_simultaneous();
        test_reset_midstream();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/id_inst_buffer.md
ID_INST_BUFFER -- requirements
Module: id_inst_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default 4, number of pc/inst entries held; power of two, 2..32.
REQ-002 SHALL have parameter PC_W, default 32, width of the pc field.
REQ-003 SHALL have parameter INST_W, default 32, width of the instruction field.
REQ-004 SHALL have parameter AF_LEVEL, default DEPTH-1, occupancy at which almost_full asserts.
REQ-005 SHALL have port clk, input, 1, clock; all state updates on its rising edge.
REQ-006 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-007 SHALL have port flush, input, 1, discard all buffered and output-stage contents.
REQ-008 SHALL have port in_valid, input, 1, IC presents a fetched instruction.
REQ-009 SHALL have port in_ready, output, 1, buffer accepts a push this cycle.
REQ-010 SHALL have port in_pc, input, PC_W, pc of the pushed instruction.
REQ-011 SHALL have port in_inst, input, INST_W, pushed instruction word.
REQ-012 SHALL have port out_valid, output, 1, out_pc/out_inst hold a live instruction for decode.
REQ-013 SHALL have port out_ready, input, 1, decode consumes the output this cycle; 0 = decode stalled.
REQ-014 SHALL have port out_pc, output, PC_W, pc presented to decode.
REQ-015 SHALL have port out_inst, output, INST_W, instruction presented to decode.
REQ-016 SHALL have port count, output, $clog2(DEPTH)+1, entries stored excluding the output stage.
REQ-017 SHALL have port almost_full, output, 1, count >= AF_LEVEL.

Function
REQ-018 SHALL store entries in a circular array addressed by wr_ptr/rd_ptr, each $clog2(DEPTH) bits, wrapping from DEPTH-1 to 0.
REQ-019 SHALL assert in_ready iff count < DEPTH; push occurs iff in_valid && in_ready.
REQ-020 SHALL hold the output stage in registers; out_pc/out_inst change only on a clock edge.
REQ-021 SHALL load the output stage when it is empty or consumed (out_valid==0 || out_ready==1): from the array head if count>0, else directly from the push (bypass), else out_valid<=0.
REQ-022 SHALL give push-to-out_valid latency of exactly 1 cycle when the array is empty and the output stage is free.
REQ-023 SHALL keep out_valid, out_pc, out_inst stable while out_valid==1 && out_ready==0 (stall hold, no loss, no duplication).
REQ-024 SHALL present instructions to decode strictly in push order.
REQ-025 SHALL, when push and head pop occur in the same cycle, leave count unchanged and write the new entry even if count==DEPTH-... only when in_ready was 1 (in_ready is not relieved by a same-cycle pop).
REQ-026 SHALL, on flush, set count=0, wr_ptr=rd_ptr=0, out_valid=0, out_pc=0, out_inst=0 next cycle; flush dominates any same-cycle push or pop (pushed data discarded).
REQ-027 SHALL drive out_pc=0 and out_inst=0 whenever out_valid is loaded 0 (decode sees a NOP bubble).
REQ-028 SHALL update count as count+push-pop, where pop = output stage loaded from array; count never exceeds DEPTH nor underflows.
REQ-029 SHALL derive almost_full combinationally from registered count.

Reset
REQ-030 SHALL, when rst==1 at a rising edge, clear wr_ptr, rd_ptr, count, out_valid, out_pc, out_inst to 0; rst dominates flush.
REQ-031 SHALL drive in_ready=1, almost_full=0 (AF_LEVEL>0) in the cycle after reset.
REQ-032 SHALL not require the storage array contents to be reset.

Verification
REQ-033 Bypass: empty buffer, out_ready=1, push pc=0xBFC00000 inst=0x24080001 -> next cycle out_valid=1 with those values, count=0.
REQ-034 Stall/fill: out_ready=0, push 5 entries with DEPTH=4 -> output holds entry 1, count=4, in_ready=0 after 5th accepted, almost_full=1 at count=3; release out_ready -> entries 2..5 in order, one per cycle.
REQ-035 Wrap: stream 3*DEPTH pushes with out_ready toggling 1,0,1,0 -> every pc delivered once, in order, no drops.
REQ-036 Flush mid-operation: count=3, out_valid=1, flush with same-cycle push -> next cycle out_valid=0, out_pc=out_inst=0, count=0, in_ready=1; next push appears one cycle later.
REQ-037 Full simultaneous: count=DEPTH, out_ready=1, in_valid=1 -> in_ready=0, push rejected, count becomes DEPTH-1.
REQ-038 Reset mid-stream: rst asserted with flush=1 and count=2 -> all outputs 0, count=0; first post-reset push delivered with 1-cycle latency.
